// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity codes and
// bit positions of the status/error vectors exported to the register block.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int RCI_RXBE    = 7;
  localparam int RCI_RXBF    = 6;
  localparam int RCI_CNT_LSB = 1;
  localparam int RCI_RDDONE  = 0;

  localparam int ERR_OERR = 2;
  localparam int ERR_FERR = 1;
  localparam int ERR_PERR = 0;

  localparam int FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_rx_decoder_rx_fifo.sv
// 16x8 first-word-fall-through receive FIFO; head reads as 0 when empty.
// Writes while full are accepted only if a read frees a slot in the same cycle.
module rx_fifo
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       wr,
  input  logic       rd,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic [4:0] count,
  output logic       empty,
  output logic       full
);

  logic [7:0] mem [FIFO_DEPTH];
  logic [3:0] wptr;
  logic [3:0] rptr;
  logic       do_rd;
  logic       do_wr;

  assign empty    = (count == 5'd0);
  assign full     = (count == 5'(FIFO_DEPTH));
  assign do_rd    = rd & ~empty;
  assign do_wr    = wr & (~full | do_rd);
  assign data_out = empty ? 8'h00 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 4'd1;
      if (do_rd) rptr <= rptr + 4'd1;
      count <= count + {4'b0, do_wr} - {4'b0, do_rd};
    end
  end

endmodule

// File: rtl/uart_rx_decoder.sv
// UART receiver: synchronizer, start/data/parity/stop framing FSM, FIFO and
// sticky error flags. Parity checking is built only with UART_RX_PARITY_CHECK_EN.
module uart_rx_decoder
  import uart_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        uart_dec,
  input  logic        en,
  input  logic        rd,
  input  logic        clr_err,
  input  logic [1:0]  parity,
  input  logic        stop_sel,
  input  logic [23:0] baudcontrol,
  output logic [7:0]  data_out,
  output logic [7:0]  uart_rci,
  output logic [2:0]  err
);

  rx_state_t   state, state_n;
  logic        rx_meta, rx_s;
  logic [23:0] clk_count, count_n;
  logic [7:0]  shreg, shreg_n;
  logic [2:0]  bit_cnt, bits_n;
  logic        stop_cnt, stop_n;
  logic        ferr_pend, ferr_n;
  logic        push;
  logic        sample;
  logic        half_hit;
  logic        rd_reg;
  logic        pop;
  logic        rddone;
  logic        oerr, ferr, perr;
  logic [4:0]  fifo_count;
  logic        fifo_empty, fifo_full;
`ifdef UART_RX_PARITY_CHECK_EN
  logic        perr_pend, perr_n;
  logic        exp_par;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_dec;
      rx_s    <= rx_meta;
    end
  end

  // Counters compare with >= so a shrinking baudcontrol never causes a wrap.
  assign sample   = (clk_count >= baudcontrol);
  assign half_hit = (clk_count >= {1'b0, baudcontrol[23:1]});

`ifdef UART_RX_PARITY_CHECK_EN
  assign exp_par = (parity == PAR_ODD) ? ~^shreg : ^shreg;
`endif

  always_comb begin
    state_n = state;
    count_n = clk_count + 24'd1;
    shreg_n = shreg;
    bits_n  = bit_cnt;
    stop_n  = stop_cnt;
    ferr_n  = ferr_pend;
`ifdef UART_RX_PARITY_CHECK_EN
    perr_n  = perr_pend;
`endif
    push    = 1'b0;
    case (state)
      IDLE: begin
        count_n = '0;
        if (!rx_s) begin
          state_n = START;
          bits_n  = '0;
          stop_n  = 1'b0;
          ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
          perr_n  = 1'b0;
`endif
        end
      end
      START: begin
        if (half_hit) begin
          count_n = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          count_n = '0;
          shreg_n = {rx_s, shreg[7:1]};
          bits_n  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = (^parity) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample) begin
          count_n = '0;
          state_n = STOP;
`ifdef UART_RX_PARITY_CHECK_EN
          if (rx_s != exp_par) perr_n = 1'b1;
`endif
        end
      end
      STOP: begin
        if (sample) begin
          count_n = '0;
          if (!rx_s) ferr_n = 1'b1;
          if (stop_sel && !stop_cnt) begin
            stop_n = 1'b1;
          end else begin
            push    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Receive disable aborts any partial frame without pushing it.
    if (!en) begin
      state_n = IDLE;
      count_n = '0;
      push    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      clk_count <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      ferr_pend <= 1'b0;
    end else begin
      state     <= state_n;
      clk_count <= count_n;
      shreg     <= shreg_n;
      bit_cnt   <= bits_n;
      stop_cnt  <= stop_n;
      ferr_pend <= ferr_n;
    end
  end

  assign pop = rd_reg & ~rd;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_reg <= 1'b0;
      rddone <= 1'b0;
      oerr   <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      rd_reg <= rd;
      rddone <= push;
      if (clr_err) begin
        oerr <= 1'b0;
        ferr <= 1'b0;
      end else begin
        if (push && ferr_n) ferr <= 1'b1;
        if (push && fifo_full && !pop) oerr <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      perr_pend <= 1'b0;
      perr      <= 1'b0;
    end else begin
      perr_pend <= perr_n;
      if (clr_err) perr <= 1'b0;
      else if (push && perr_n) perr <= 1'b1;
    end
  end
`else
  assign perr = 1'b0;
`endif

  rx_fifo u_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .wr       (push),
    .rd       (pop),
    .data_in  (shreg_n),
    .data_out (data_out),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_comb begin
    uart_rci = '0;
    uart_rci[RCI_RXBE] = fifo_empty;
    uart_rci[RCI_RXBF] = fifo_full;
    uart_rci[RCI_CNT_LSB +: 5] = fifo_count;
    uart_rci[RCI_RDDONE] = rddone;
  end

  always_comb begin
    err = '0;
    err[ERR_OERR] = oerr;
    err[ERR_FERR] = ferr;
    err[ERR_PERR] = perr;
  end

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Directed bench for uart_rx_decoder at baudcontrol=9 (10 cycles per bit);
// PERR expectations follow UART_RX_PARITY_CHECK_EN.
module tb_uart_rx_decoder;

  logic        clk = 1'b0;
  logic        nrst;
  logic        uart_dec;
  logic        en;
  logic        rd;
  logic        clr_err;
  logic [1:0]  parity;
  logic        stop_sel;
  logic [23:0] baudcontrol;
  logic [7:0]  data_out;
  logic [7:0]  uart_rci;
  logic [2:0]  err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rddone_cnt  = 0;
  int rddone_cyc  = 0;
  int start_cyc   = 0;
  int rd_before   = 0;

`ifdef UART_RX_PARITY_CHECK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif
  localparam int BIT_CYC = 10;

  uart_rx_decoder dut (
    .clk         (clk),
    .nrst        (nrst),
    .uart_dec    (uart_dec),
    .en          (en),
    .rd          (rd),
    .clr_err     (clr_err),
    .parity      (parity),
    .stop_sel    (stop_sel),
    .baudcontrol (baudcontrol),
    .data_out    (data_out),
    .uart_rci    (uart_rci),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (uart_rci[0]) begin
      rddone_cnt <= rddone_cnt + 1;
      rddone_cyc <= cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_bit(input logic b);
    uart_dec = b;
    repeat (BIT_CYC) @(negedge clk);
  endtask

  // Sends one frame starting at a negedge, then holds the line idle.
  task automatic applyStimulus(input logic [7:0] data, input logic use_par,
                               input logic par_bit, input logic two_stop,
                               input logic stop1, input logic stop2);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (use_par) drive_bit(par_bit);
    drive_bit(stop1);
    if (two_stop) drive_bit(stop2);
    uart_dec = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic pop_byte();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    nrst = 1'b0; uart_dec = 1'b1; en = 1'b1; rd = 1'b0; clr_err = 1'b0;
    parity = 2'b00; stop_sel = 1'b0; baudcontrol = 24'd9;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_rci", 32'(uart_rci), 32'h80);
    checkOutput("rst_dout", 32'(data_out), 32'h00);
    checkOutput("rst_err", 32'(err), 32'h0);

    pop_byte();
    checkOutput("pop_empty_rci", 32'(uart_rci), 32'h80);

    $display("[TB] 0xA5 no parity");
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("a5_dout", 32'(data_out), 32'hA5);
    checkOutput("a5_rci", 32'(uart_rci), 32'h02);
    checkOutput("a5_err", 32'(err), 32'h0);
    checkOutput("a5_rddone_cnt", 32'(rddone_cnt), 32'd1);
    checkOutput("a5_latency", 32'(rddone_cyc - start_cyc), 32'd98);
    pop_byte();
    checkOutput("a5_pop_rci", 32'(uart_rci), 32'h80);
    checkOutput("a5_pop_dout", 32'(data_out), 32'h00);

    $display("[TB] even parity");
    parity = 2'b01;
    applyStimulus(8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("par_bad_dout", 32'(data_out), 32'h03);
    checkOutput("par_bad_err", 32'(err), 32'({2'b00, PERR_EXP}));
    checkOutput("par_latency", 32'(rddone_cyc - start_cyc), 32'd108);
    pulse_clr();
    checkOutput("par_clr_err", 32'(err), 32'h0);
    pop_byte();
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("par_ok_dout", 32'(data_out), 32'h07);
    checkOutput("par_ok_err", 32'(err), 32'h0);
    pop_byte();
    parity = 2'b10;
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("odd_bad_err", 32'(err), 32'({2'b00, PERR_EXP}));
    pulse_clr();
    pop_byte();
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("odd_ok_err", 32'(err), 32'h0);
    pop_byte();
    parity = 2'b00;

    $display("[TB] framing");
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ferr1_dout", 32'(data_out), 32'h55);
    checkOutput("ferr1_err", 32'(err), 32'h2);
    checkOutput("ferr1_rci", 32'(uart_rci), 32'h02);
    pulse_clr();
    pop_byte();
    stop_sel = 1'b1;
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("ferr2_dout", 32'(data_out), 32'h55);
    checkOutput("ferr2_err", 32'(err), 32'h2);
    checkOutput("two_stop_latency", 32'(rddone_cyc - start_cyc), 32'd108);
    pulse_clr();
    pop_byte();
    applyStimulus(8'h3A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("two_stop_ok_dout", 32'(data_out), 32'h3A);
    checkOutput("two_stop_ok_err", 32'(err), 32'h0);
    pop_byte();
    stop_sel = 1'b0;

    $display("[TB] glitch");
    rd_before = rddone_cnt;
    uart_dec = 1'b0;
    repeat (3) @(negedge clk);
    uart_dec = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitch_rci", 32'(uart_rci), 32'h80);
    checkOutput("glitch_rddone", 32'(rddone_cnt), 32'(rd_before));

    $display("[TB] overrun");
    for (int b = 0; b < 17; b++) applyStimulus(8'(b), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("ovr_rci", 32'(uart_rci), 32'h60);
    checkOutput("ovr_err", 32'(err), 32'h4);
    checkOutput("ovr_head", 32'(data_out), 32'h00);
    for (int b = 0; b < 16; b++) begin
      checkOutput($sformatf("ovr_pop%0d", b), 32'(data_out), 32'(b));
      pop_byte();
    end
    checkOutput("ovr_empty_rci", 32'(uart_rci), 32'h80);
    checkOutput("ovr_empty_dout", 32'(data_out), 32'h00);

    $display("[TB] enable drop mid-frame");
    rd_before = rddone_cnt;
    uart_dec = 1'b0;
    repeat (40) @(negedge clk);
    en = 1'b0;
    uart_dec = 1'b1;
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("en_rci", 32'(uart_rci), 32'h80);
    checkOutput("en_rddone", 32'(rddone_cnt), 32'(rd_before));

    $display("[TB] reset mid-frame");
    uart_dec = 1'b0;
    repeat (40) @(negedge clk);
    nrst = 1'b0;
    uart_dec = 1'b1;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("rst2_rci", 32'(uart_rci), 32'h80);
    checkOutput("rst2_err", 32'(err), 32'h0);
    applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("rst2_dout", 32'(data_out), 32'h3C);
    checkOutput("rst2_rci_after", 32'(uart_rci), 32'h02);
    checkOutput("rst2_err_after", 32'(err), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_decoder.md
# uart_rx_decoder

UART receiver paired with the existing UART transmitter in the memory-mapped UART peripheral. It oversamples the RX pin at the core clock, frames start/data/optional parity/stop bits using the shared BAUDCONTROL divisor, and stores received bytes in a 16-entry FIFO read by the CPU through UART_DOUT. Status and error flags are exported to the UART register block.

## Interface
- No parameters; depth is fixed at 16 bytes.
- clk  in  1  core clock
- nrst  in  1  reset, synchronous, active-low
- uart_dec  in  1  RX pin, asynchronous
- en  in  1  UART_CON receive enable; low forces IDLE and leaves FIFO contents intact
- rd  in  1  pop request; the FIFO pops once on each 1→0 transition of rd (registered rd_reg & !rd)
- clr_err  in  1  clears all sticky error flags
- parity  in  2  00/11 none, 01 even, 10 odd
- stop_sel  in  1  0: one stop bit, 1: two stop bits
- baudcontrol  in  24  Fclk/Fbaud − 1
- data_out  out  8  FIFO head (first-word-fall-through); 0 when empty
- uart_rci  out  8  [7] RXBE (FIFO empty), [6] RXBF (FIFO full), [5:1] FIFO count 0..16, [0] RDDONE (one-cycle pulse on push)
- err  out  3  sticky {OERR overrun, FERR framing, PERR parity}

## Operation
- The RX pin passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized rx_s.
- FSM states and transitions:
  - IDLE: if en and rx_s==0 → START, with clk_count cleared.
  - START: count to baudcontrol>>1 (mid-bit). If rx_s==0 → DATA with count cleared; otherwise it is a false start → IDLE.
  - DATA: count 0..baudcontrol and sample at count==baudcontrol. Shift LSB-first with shreg <= {rx_s, shreg[7:1]}. After 8 samples → PARITY if ^parity, else STOP.
  - PARITY: sample one bit. Expected value is ^shreg for even (01) or ~^shreg for odd (10). On mismatch, set pending perr.
  - STOP: sample one bit; rx_s==0 sets pending ferr. If stop_sel and this is the first stop bit → STOP again. Otherwise push {shreg} and → IDLE immediately at the mid-bit sample, so the next start edge can be caught.
- A push writes shreg to the FIFO, pulses RDDONE, and ORs pending perr/ferr into err. Bytes with errors are still stored.
- If the FIFO is full when a push occurs (and no pop happens in the same cycle), the byte is dropped and OERR is set.
- A simultaneous push and pop are both performed and count is unchanged. A pop while empty is ignored.
- en low: FSM → IDLE on the next edge and any partial frame is discarded. FIFO, err, and rd handling remain active.
- clk_count is 24 bits and compares with < baudcontrol, so there is no wrap. If baudcontrol changes mid-frame, the new value takes effect on the next compare.

## Timing
- Reset values: state IDLE, sync flops 1, data_out 0, uart_rci 8'h80, err 0, FIFO empty.
- Pin to detection: 2 cycles of synchronizer latency plus 1 cycle in IDLE.
- Bit period: baudcontrol+1 cycles. The first data sample is taken (baudcontrol>>1)+1+baudcontrol+1 cycles after START entry.
- Push occurs on the clock edge that samples the last stop bit. data_out, RXBE, and count update in the following cycle. RDDONE is high for exactly that one cycle.
- Pop is registered: data_out advances in the cycle after the rd falling edge is detected.
- clr_err takes precedence over a same-cycle error set. Error flags clear on the next edge.

## Configuration
- UART_RX_PARITY_CHECK_EN defined: the PARITY state compares the received bit against the expected value and PERR is generated as described above.
- UART_RX_PARITY_CHECK_EN undefined: the PARITY state still consumes one bit period (so framing is preserved), but no comparison logic is built and err[0] is tied to 0.

## Structure
- Package uart_pkg holds:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP)
  - parity codes (PAR_NONE, PAR_EVEN, PAR_ODD)
  - uart_rci bit indices and err bit indices
- The transmitter is to import the same package.
- One sub-module, rx_fifo: 16×8, FWFT, with ports wr/rd/data_in/data_out/count[4:0]/empty/full.

## Test plan
- baudcontrol=9, no parity, 1 stop, send 0xA5 → data_out=0xA5, count=1, RDDONE pulses once, err=000.
- Even parity, send 0x03 with parity bit 1 → byte stored and PERR=1. Then pulse clr_err → err=000.
- 0x55 with the stop bit driven 0 → byte stored and FERR=1. Repeat with stop_sel=1 and only the second stop bit low → FERR=1.
- Low glitch of 3 cycles on uart_dec (baudcontrol=9) → returns to IDLE, count stays 0.
- Send 17 bytes 0x00..0x10 without reading → count=16, RXBF=1, OERR=1, head=0x00. Pop 16 times → bytes 0x00..0x0F in order, RXBE=1.
- Assert nrst low mid-DATA, release, then send 0x3C → only 0x3C is stored, uart_rci=8'h02 (not empty, count=1) after the push.
